// File: rtl/idelay_tap_ctrl.sv
// rtl/idelay_tap_ctrl.sv - IDELAY tap-change sequencer (EN_VTC off, LOAD, settle), optional readback check via IDELAY_READBACK_CHECK_EN
module idelay_tap_ctrl #(
  parameter int unsigned VTC_WAIT   = 10,
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic       ref_clk_400m,
  input  logic       reset,
  input  logic       i_idelay_rdy,
  input  logic       i_req,
  input  logic [8:0] i_tap,
  input  logic [8:0] i_cnt_value_out,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic       o_en_vtc,
  output logic       o_load,
  output logic [8:0] o_cnt_value
);

  typedef enum logic [2:0] {
    S_WAIT_RDY,
    S_IDLE,
    S_VTC_OFF,
    S_LOAD,
    S_SETTLE,
    S_DONE
  } state_t;

  // Counters count down to zero, so each timed state reloads with its length minus one.
  localparam logic [7:0] VTC_RELOAD    = 8'(VTC_WAIT - 1);
  localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYC - 1);

  state_t     state;
  state_t     state_nxt;
  logic       abort;
  logic [7:0] wait_cnt;
  logic [8:0] tap_q;

  // State register.
  always_ff @(posedge ref_clk_400m) begin
    if (reset) begin
      state <= S_WAIT_RDY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore outputs; loss of IDELAYCTRL ready overrides every transition.
  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    o_ready   = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    o_en_vtc  = 1'b1;
    o_load    = 1'b0;
    case (state)
      S_WAIT_RDY: begin
        if (i_idelay_rdy) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_req) state_nxt = (i_tap == o_cnt_value) ? S_DONE : S_VTC_OFF;
      end
      S_VTC_OFF: begin
        o_busy   = 1'b1;
        o_en_vtc = 1'b0;
        if (wait_cnt == 8'd0) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        o_busy    = 1'b1;
        o_en_vtc  = 1'b0;
        o_load    = 1'b1;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        o_busy   = 1'b1;
        o_en_vtc = 1'b0;
        if (wait_cnt == 8'd0) state_nxt = S_DONE;
      end
      S_DONE: begin
        o_busy    = 1'b1;
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_WAIT_RDY;
    endcase
    if (state != S_WAIT_RDY && !i_idelay_rdy) begin
      state_nxt = S_WAIT_RDY;
      abort     = 1'b1;
    end
  end

  // Wait counter, latched tap, applied tap and sticky error flag.
  always_ff @(posedge ref_clk_400m) begin
    if (reset) begin
      wait_cnt    <= 8'd0;
      tap_q       <= 9'd0;
      o_cnt_value <= 9'd0;
      o_err       <= 1'b0;
    end else begin
      if (state_nxt != state) begin
        case (state_nxt)
          S_VTC_OFF: wait_cnt <= VTC_RELOAD;
          S_SETTLE:  wait_cnt <= SETTLE_RELOAD;
          default:   wait_cnt <= 8'd0;
        endcase
      end else if (wait_cnt != 8'd0) begin
        wait_cnt <= wait_cnt - 8'd1;
      end

      if (state == S_IDLE && state_nxt == S_VTC_OFF) tap_q <= i_tap;
      // CNTVALUEIN changes on entry to LOAD so it is already valid while LOAD is high.
      if (state == S_VTC_OFF && state_nxt == S_LOAD) o_cnt_value <= tap_q;

      if (abort) o_err <= 1'b1;
`ifdef IDELAY_READBACK_CHECK_EN
      if (state == S_SETTLE && wait_cnt == 8'd0 && i_cnt_value_out != tap_q) o_err <= 1'b1;
`endif
    end
  end

`ifndef IDELAY_READBACK_CHECK_EN
  logic unused_cnt_value_out;
  assign unused_cnt_value_out = ^i_cnt_value_out;
`endif

endmodule

// File: tb/tb_idelay_tap_ctrl.sv
// tb/tb_idelay_tap_ctrl.sv - randomized self-checking bench for idelay_tap_ctrl against a timeline model
module tb_idelay_tap_ctrl;

  localparam int VW      = 10;
  localparam int SC      = 8;
  localparam int SEQ_LEN = VW + SC + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       idelay_rdy = 1'b0;
  logic       req = 1'b0;
  logic [8:0] tap = 9'd0;
  logic [8:0] cnt_value_out = 9'd0;
  logic       ready, busy, done, err, en_vtc, load;
  logic [8:0] cnt_value;

  always #5 clk = ~clk;

  idelay_tap_ctrl #(.VTC_WAIT(VW), .SETTLE_CYC(SC)) dut (
    .ref_clk_400m    (clk),
    .reset           (reset),
    .i_idelay_rdy    (idelay_rdy),
    .i_req           (req),
    .i_tap           (tap),
    .i_cnt_value_out (cnt_value_out),
    .o_ready         (ready),
    .o_busy          (busy),
    .o_done          (done),
    .o_err           (err),
    .o_en_vtc        (en_vtc),
    .o_load          (load),
    .o_cnt_value     (cnt_value)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;
  int load_seen = 0;

  // Model: mode 0 = waiting for ready, 1 = idle, 2 = sequence running; m_k is the cycle offset since acceptance.
  int         m_mode = 0;
  int         m_k = 0;
  int         m_len = 0;
  logic [8:0] m_tgt = 9'd0;
  logic [8:0] m_applied = 9'd0;
  logic       m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic compare_outputs();
    logic run;
    run = (m_mode == 2);
    check("ready",  32'(ready),     32'(m_mode == 1));
    check("busy",   32'(busy),      32'(run));
    check("done",   32'(done),      32'(run && m_k == m_len));
    check("load",   32'(load),      32'(run && m_len > 1 && m_k == VW + 1));
    check("en_vtc", 32'(en_vtc),    32'(!(run && m_len > 1 && m_k < m_len)));
    check("cnt",    32'(cnt_value), 32'(m_applied));
    check("err",    32'(err),       32'(m_err));
    if (done === 1'b1) done_seen++;
    if (load === 1'b1) load_seen++;
  endtask

  task automatic step(input logic s_rst, input logic s_rdy, input logic s_req,
                      input logic [8:0] s_tap, input logic [8:0] s_rb);
    @(negedge clk);
    compare_outputs();
    reset = s_rst; idelay_rdy = s_rdy; req = s_req; tap = s_tap; cnt_value_out = s_rb;
    @(posedge clk);
    if (s_rst) begin
      m_mode = 0; m_applied = 9'd0; m_err = 1'b0;
    end else if (m_mode == 0) begin
      if (s_rdy) m_mode = 1;
    end else if (!s_rdy) begin
      m_mode = 0; m_err = 1'b1;
    end else if (m_mode == 1) begin
      if (s_req) begin
        m_tgt = s_tap; m_k = 1; m_mode = 2;
        m_len = (s_tap == m_applied) ? 1 : SEQ_LEN;
      end
    end else begin
`ifdef IDELAY_READBACK_CHECK_EN
      if (m_len > 1 && m_k == VW + SC + 1 && s_rb != m_tgt) m_err = 1'b1;
`endif
      if (m_k == m_len) m_mode = 1;
      else begin
        m_k++;
        if (m_len > 1 && m_k == VW + 1) m_applied = m_tgt;
      end
    end
    #1;
  endtask

  task automatic idle_steps(input int n, input logic [8:0] rb);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 9'd0, rb);
  endtask

  initial begin
    logic       r_rst, r_rdy, r_req;
    logic [8:0] r_tap, r_rb;
    logic       exp_rb_err;

    // Reset, ready rises at cycle 5.
    step(1'b1, 1'b0, 1'b0, 9'd0, 9'd0);
    step(1'b1, 1'b0, 1'b0, 9'd0, 9'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 9'd0, 9'd0);
    check("rst_ready", 32'(ready), 32'd0);
    step(1'b0, 1'b1, 1'b0, 9'd0, 9'd0);
    check("ready_up", 32'(ready), 32'd1);
    check("cnt_zero", 32'(cnt_value), 32'd0);

    // Full sequence to 0x0A5.
    done_seen = 0; load_seen = 0;
    step(1'b0, 1'b1, 1'b1, 9'h0A5, 9'h0A5);
    idle_steps(22, 9'h0A5);
    check("seq_done_cnt", 32'(done_seen), 32'd1);
    check("seq_load_cnt", 32'(load_seen), 32'd1);
    check("seq_cnt_a5", 32'(cnt_value), 32'h0A5);

    // Same tap again: immediate completion, no load.
    done_seen = 0; load_seen = 0;
    step(1'b0, 1'b1, 1'b1, 9'h0A5, 9'h0A5);
    idle_steps(3, 9'h0A5);
    check("eq_done_cnt", 32'(done_seen), 32'd1);
    check("eq_load_cnt", 32'(load_seen), 32'd0);

    // Requests held while busy are not queued.
    done_seen = 0;
    step(1'b0, 1'b1, 1'b1, 9'h033, 9'h033);
    for (int i = 0; i < SEQ_LEN - 1; i++) step(1'b0, 1'b1, 1'b1, 9'(i + 7), 9'h033);
    step(1'b0, 1'b1, 1'b0, 9'h000, 9'h033);
    idle_steps(3, 9'h033);
    check("busy_req_done", 32'(done_seen), 32'd1);
    check("busy_req_cnt", 32'(cnt_value), 32'h033);

    // Ready drops mid-settle.
    done_seen = 0;
    step(1'b0, 1'b1, 1'b1, 9'h1FF, 9'h1FF);
    idle_steps(VW + 3, 9'h1FF);
    step(1'b0, 1'b0, 1'b0, 9'h000, 9'h1FF);
    check("abort_en_vtc", 32'(en_vtc), 32'd1);
    check("abort_err", 32'(err), 32'd1);
    check("abort_ready", 32'(ready), 32'd0);
    idle_steps(4, 9'h1FF);
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_cnt_kept", 32'(cnt_value), 32'h1FF);

    // Readback mismatch for tap 0x100.
    step(1'b1, 1'b0, 1'b0, 9'd0, 9'd0);
    step(1'b0, 1'b1, 1'b0, 9'd0, 9'd0);
    done_seen = 0;
    step(1'b0, 1'b1, 1'b1, 9'h100, 9'h000);
    idle_steps(SEQ_LEN + 2, 9'h000);
`ifdef IDELAY_READBACK_CHECK_EN
    exp_rb_err = 1'b1;
`else
    exp_rb_err = 1'b0;
`endif
    check("rb_done", 32'(done_seen), 32'd1);
    check("rb_err", 32'(err), 32'(exp_rb_err));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 499) == 0);
      r_rdy = ($urandom_range(0, 149) != 0);
      r_req = ($urandom_range(0, 7) == 0);
      r_tap = ($urandom_range(0, 1) == 0) ? m_applied : 9'($urandom_range(0, 511));
      r_rb  = ($urandom_range(0, 4) != 0) ? m_tgt : 9'($urandom_range(0, 511));
      if (m_mode == 0 && $urandom_range(0, 3) == 0) r_rdy = 1'b1;
      step(r_rst, r_rdy, r_req, r_tap, r_rb);
    end
    @(negedge clk);
    compare_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/idelay_tap_ctrl.md
IDELAY_TAP_CTRL -- requirements
Module: idelay_tap_ctrl

Interface
REQ-001 Parameter VTC_WAIT, default 10: number of cycles o_en_vtc is held low before the load pulse (range 1-255).
REQ-002 Parameter SETTLE_CYC, default 8: number of cycles after the load pulse before completion (range 1-255).
REQ-003 ref_clk_400m  in  1: the single clock; all logic rising-edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 i_idelay_rdy  in  1: IDELAYCTRL ready.
REQ-006 i_req  in  1: tap-change request, level-sampled.
REQ-007 i_tap  in  9: requested tap count.
REQ-008 i_cnt_value_out  in  9: delay-line CNTVALUEOUT readback.
REQ-009 o_ready  out  1: controller can accept i_req this cycle.
REQ-010 o_busy  out  1: a tap-change sequence is in progress.
REQ-011 o_done  out  1: one-cycle completion pulse.
REQ-012 o_err  out  1: sticky readback-mismatch or ready-loss flag.
REQ-013 o_en_vtc  out  1: drives delay-line EN_VTC.
REQ-014 o_load  out  1: drives delay-line LOAD.
REQ-015 o_cnt_value  out  9: drives delay-line CNTVALUEIN; holds the last applied tap.

Function
REQ-016 The FSM SHALL implement the states WAIT_RDY, IDLE, VTC_OFF, LOAD, SETTLE and DONE.
REQ-017 WAIT_RDY: o_ready=0 and o_en_vtc=1; the FSM SHALL move to IDLE on the first cycle i_idelay_rdy=1.
REQ-018 IDLE: o_ready=1; when i_req=1 the FSM SHALL latch i_tap and go to VTC_OFF; requests arriving while o_ready=0 SHALL be ignored, not queued.
REQ-019 If the latched tap equals o_cnt_value, the FSM SHALL go directly to DONE, skipping VTC_OFF, LOAD and SETTLE.
REQ-020 VTC_OFF: o_en_vtc=0 for exactly VTC_WAIT cycles, then the FSM SHALL go to LOAD.
REQ-021 LOAD: o_load=1 for exactly one cycle; o_cnt_value SHALL take the latched tap in that cycle and hold it afterwards.
REQ-022 SETTLE: o_en_vtc=0 for exactly SETTLE_CYC cycles, then the FSM SHALL go to DONE.
REQ-023 DONE: o_done=1 for one cycle and o_en_vtc=1, then the FSM SHALL return to IDLE.
REQ-024 Latency: with acceptance at edge T, o_done SHALL be high in cycle T+VTC_WAIT+SETTLE_CYC+2 (20 cycles at defaults); on the equal-tap path it SHALL be high in cycle T+1.
REQ-025 o_busy SHALL be 1 exactly in VTC_OFF, LOAD, SETTLE and DONE.
REQ-026 If i_idelay_rdy falls in any state other than WAIT_RDY, the FSM SHALL abort to WAIT_RDY next cycle with o_en_vtc=1, o_load=0 and no o_done, set o_err, and leave o_cnt_value unchanged.
REQ-027 The wait counter SHALL be 8-bit, reloaded on each state entry, and SHALL never wrap.
REQ-028 o_err SHALL remain set until reset.

Reset
REQ-029 On reset=1 at a clock edge: state=WAIT_RDY, o_en_vtc=1, o_load=0, o_cnt_value=0, o_ready=0, o_busy=0, o_done=0, o_err=0.
REQ-030 Reset SHALL take priority over every other event, including mid-sequence and simultaneously with i_req.

Configuration
REQ-031 Macro IDELAY_READBACK_CHECK_EN defined: in the last SETTLE cycle, if i_cnt_value_out differs from the latched tap, o_err SHALL be set; the sequence still completes with o_done.
REQ-032 Macro IDELAY_READBACK_CHECK_EN undefined: no compare logic; i_cnt_value_out is unused; o_err is set only by ready loss (REQ-026).

Verification
REQ-033 Reset, then i_idelay_rdy=1 at cycle 5 -> o_ready=1 from cycle 6; o_cnt_value=0.
REQ-034 i_req with i_tap=0x0A5 at edge T, defaults -> o_en_vtc low for cycles T+1..T+19, o_load high only in T+11, o_done high in T+20, o_cnt_value=0x0A5.
REQ-035 Repeat i_req with i_tap=0x0A5 -> o_done in T+1, o_load never asserted, o_en_vtc stays 1.
REQ-036 i_req asserted while o_busy=1 -> ignored: no second sequence, exactly one o_done.
REQ-037 i_idelay_rdy dropped in SETTLE -> WAIT_RDY next cycle, o_en_vtc=1, o_err=1, no o_done.
REQ-038 With IDELAY_READBACK_CHECK_EN defined and i_cnt_value_out forced to 0x000 for tap 0x100 -> o_done pulses and o_err=1; without the macro -> o_err=0.
